// File: rtl/axis_video_gen.sv
// AXI4-Stream test-pattern generator: frames of IMG_WIDTH x IMG_HEIGHT pixels with optional blanking.
// Define AXIS_VGEN_LFSR_EN to make mode 3 an LFSR pattern; otherwise mode 3 is an 8x8 checkerboard.
module axis_video_gen #(
  parameter int unsigned IMG_WIDTH  = 2560,
  parameter int unsigned IMG_HEIGHT = 1440,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned H_BLANK    = 0,
  parameter int unsigned V_BLANK    = 0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           en,
  input  logic [1:0]                     mode,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           frame_done,
  output logic [15:0]                    frame_cnt
);

  localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned TW = DATA_WIDTH * CHANNELS;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              rst_sync_q;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [31:0]             blank_q, blank_d;
  logic [TW-1:0]           tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic                    frame_done_q, frame_done_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
`ifdef AXIS_VGEN_LFSR_EN
  logic [15:0]             lfsr_q, lfsr_d;
  logic [31:0]             l32;
`endif

  logic                    run_ok;
  logic                    start;
  logic                    load;
  logic [DATA_WIDTH-1:0]   p;
  logic [31:0]             x32, y32;

  assign run_ok = rst_sync_q[1];

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    blank_d      = blank_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef AXIS_VGEN_LFSR_EN
    lfsr_d       = lfsr_q;
`endif
    start        = 1'b0;
    load         = 1'b0;
    p            = '0;
    x32          = '0;
    y32          = '0;

    case (state_q)
      S_IDLE: begin
        if (run_ok && en) start = 1'b1;
      end
      S_ACTIVE: begin
        if (tvalid_q && m_axis_tready) begin
          cnt_d = cnt_q + 1'b1;
`ifdef AXIS_VGEN_LFSR_EN
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
          if (!tlast_q) begin
            x_d  = x_q + 1'b1;
            load = 1'b1;
          end else if (y_q != YW'(IMG_HEIGHT - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (H_BLANK != 0) begin
              state_d  = S_HBLANK;
              blank_d  = 32'(H_BLANK - 1);
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
            end else begin
              load = 1'b1;
            end
          end else begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            tuser_d      = 1'b0;
            if (V_BLANK != 0) begin
              state_d = S_VBLANK;
              blank_d = 32'(V_BLANK - 1);
            end else if (en) begin
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) begin
          state_d = S_ACTIVE;
          load    = 1'b1;
        end else begin
          blank_d = blank_q - 32'd1;
        end
      end
      S_VBLANK: begin
        if (blank_q != '0) blank_d = blank_q - 32'd1;
        else if (en)       start   = 1'b1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_ACTIVE;
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
      mode_d  = mode;
`ifdef AXIS_VGEN_LFSR_EN
      lfsr_d  = 16'hACE1;
`endif
      load    = 1'b1;
    end

    // Beat contents are computed from the next-state counters so they are registered with tvalid.
    if (load) begin
      x32 = 32'(x_d);
      y32 = 32'(y_d);
      case (mode_d)
        2'd0:    p = cnt_d;
        2'd1:    p = DATA_WIDTH'(x32);
        2'd2:    p = DATA_WIDTH'(y32);
        default: begin
`ifdef AXIS_VGEN_LFSR_EN
          l32 = 32'(lfsr_d);
          p   = DATA_WIDTH'(l32);
`else
          p   = {DATA_WIDTH{x32[3] ^ y32[3]}};
`endif
        end
      endcase
      tvalid_d = 1'b1;
      tlast_d  = (x_d == XW'(IMG_WIDTH - 1));
      tuser_d  = (x_d == '0) && (y_d == '0);
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        tdata_d[c*DATA_WIDTH +: DATA_WIDTH] = p + DATA_WIDTH'(c);
      end
    end
`ifdef AXIS_VGEN_LFSR_EN
    else begin
      l32 = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q   <= '0;
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= '0;
      cnt_q        <= '0;
      blank_q      <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef AXIS_VGEN_LFSR_EN
      lfsr_q       <= 16'hACE1;
`endif
    end else begin
      rst_sync_q   <= {rst_sync_q[0], 1'b1};
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef AXIS_VGEN_LFSR_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_gen.sv
// Directed bench for axis_video_gen: three small instances (plain, blanking, three-channel).
module tb_axis_video_gen;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  logic        a_en, a_tready, a_tvalid, a_tlast, a_tuser, a_fdone;
  logic [1:0]  a_mode;
  logic [7:0]  a_tdata;
  logic [15:0] a_fcnt;

  logic        b_en, b_tready, b_tvalid, b_tlast, b_tuser, b_fdone;
  logic [1:0]  b_mode;
  logic [7:0]  b_tdata;
  logic [15:0] b_fcnt;

  logic        c_en, c_tready, c_tvalid, c_tlast, c_tuser, c_fdone;
  logic [1:0]  c_mode;
  logic [23:0] c_tdata;
  logic [15:0] c_fcnt;

  axis_video_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .CHANNELS(1),
                   .H_BLANK(0), .V_BLANK(0)) u_a (
    .clk(clk), .resetn(resetn), .en(a_en), .mode(a_mode),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .frame_done(a_fdone), .frame_cnt(a_fcnt));

  axis_video_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .CHANNELS(1),
                   .H_BLANK(2), .V_BLANK(3)) u_b (
    .clk(clk), .resetn(resetn), .en(b_en), .mode(b_mode),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .frame_done(b_fdone), .frame_cnt(b_fcnt));

  axis_video_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .CHANNELS(3),
                   .H_BLANK(0), .V_BLANK(0)) u_c (
    .clk(clk), .resetn(resetn), .en(c_en), .mode(c_mode),
    .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid), .m_axis_tready(c_tready),
    .m_axis_tlast(c_tlast), .m_axis_tuser(c_tuser),
    .frame_done(c_fdone), .frame_cnt(c_fcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    a_tready = 1'b1; b_tready = 1'b1; c_tready = 1'b1;
    a_mode = 2'd0; b_mode = 2'd0; c_mode = 2'd0;
    repeat (3) tick();
    checks++;
    if ({a_tvalid, a_tlast, a_tuser, a_fdone, a_tdata, a_fcnt} !== 28'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {a_tvalid, a_tlast, a_tuser, a_fdone, a_tdata, a_fcnt});
    end
    checks++;
    if ({b_tvalid, c_tvalid, c_tdata, c_fcnt} !== 42'h0) begin
      failures++;
      $display("FAIL reset_bc got=%h exp=0", {b_tvalid, c_tvalid, c_tdata, c_fcnt});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic;
    logic [11:0] exp_v, got_v;
    a_mode = 2'd1; a_tready = 1'b1; a_en = 1'b1;
    tick();
    a_en = 1'b0;
    for (int b = 0; b < 12; b++) begin
      if (b == 6) a_mode = 2'd2;
      exp_v = {1'b1, (b % 4) == 3, b == 0, 1'b0, 8'(b % 4)};
      got_v = {a_tvalid, a_tlast, a_tuser, a_fdone, a_tdata};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h exp=%h", b, got_v, exp_v);
      end
      tick();
    end
    checks++;
    if ({a_fdone, a_tvalid, a_fcnt} !== {1'b1, 1'b0, 16'd1}) begin
      failures++;
      $display("FAIL basic_done got=%h exp=%h", {a_fdone, a_tvalid, a_fcnt}, {1'b1, 1'b0, 16'd1});
    end
    tick();
    checks++;
    if ({a_fdone, a_tvalid} !== 2'b00) begin
      failures++;
      $display("FAIL basic_idle got=%b exp=00", {a_fdone, a_tvalid});
    end
  endtask

  task automatic test_backpressure;
    int beats = 0;
    logic [10:0] exp_v, got_v;
    a_mode = 2'd1; a_tready = 1'b1; a_en = 1'b1;
    tick();
    a_en = 1'b0;
    for (int cyc = 0; cyc < 60 && beats < 12; cyc++) begin
      a_tready = (cyc % 2) == 0;
      exp_v = {1'b1, (beats % 4) == 3, beats == 0, 8'(beats % 4)};
      got_v = {a_tvalid, a_tlast, a_tuser, a_tdata};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL bp_cycle%0d got=%h exp=%h", cyc, got_v, exp_v);
      end
      if (a_tready) beats++;
      tick();
    end
    a_tready = 1'b1;
    checks++;
    if ({a_fdone, a_tvalid, a_fcnt} !== {1'b1, 1'b0, 16'd2}) begin
      failures++;
      $display("FAIL bp_done got=%h exp=%h", {a_fdone, a_tvalid, a_fcnt}, {1'b1, 1'b0, 16'd2});
    end
  endtask

  task automatic test_en_drop;
    int beats = 0;
    a_mode = 2'd1; a_tready = 1'b1; a_en = 1'b1;
    tick();
    for (int cyc = 0; cyc < 30 && a_tvalid; cyc++) begin
      if (beats == 6) a_en = 1'b0;
      checks++;
      if (a_tdata !== 8'(beats % 4)) begin
        failures++;
        $display("FAIL endrop_beat%0d got=%h exp=%h", beats, a_tdata, 8'(beats % 4));
      end
      beats++;
      tick();
    end
    checks++;
    if (beats !== 12) begin
      failures++;
      $display("FAIL endrop_count got=%0d exp=12", beats);
    end
    repeat (3) tick();
    checks++;
    if ({a_tvalid, a_fcnt} !== {1'b0, 16'd3}) begin
      failures++;
      $display("FAIL endrop_idle got=%h exp=%h", {a_tvalid, a_fcnt}, {1'b0, 16'd3});
    end
  endtask

  task automatic test_blanking;
    logic [11:0] exp_v, got_v;
    int n = 0;
    b_mode = 2'd2; b_tready = 1'b1; b_en = 1'b1;
    tick();
    for (int line = 0; line < 3; line++) begin
      for (int i = 0; i < 4; i++) begin
        exp_v = {1'b1, i == 3, (line == 0) && (i == 0), 1'b0, 8'(line)};
        got_v = {b_tvalid, b_tlast, b_tuser, b_fdone, b_tdata};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL blank_l%0d_b%0d got=%h exp=%h", line, i, got_v, exp_v);
        end
        tick();
      end
      for (int j = 0; j < ((line < 2) ? 2 : 3); j++) begin
        checks++;
        if ({b_tvalid, b_fdone} !== {1'b0, (line == 2) && (j == 0)}) begin
          failures++;
          $display("FAIL blank_gap_l%0d_c%0d got=%b exp=%b", line, j,
                   {b_tvalid, b_fdone}, {1'b0, (line == 2) && (j == 0)});
        end
        tick();
      end
    end
    checks++;
    if ({b_tvalid, b_tuser, b_tdata, b_fcnt} !== {1'b1, 1'b1, 8'd0, 16'd1}) begin
      failures++;
      $display("FAIL blank_restart got=%h exp=%h", {b_tvalid, b_tuser, b_tdata, b_fcnt},
               {1'b1, 1'b1, 8'd0, 16'd1});
    end
    b_en = 1'b0;
    tick();
    while (!b_fdone && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (b_fdone !== 1'b1) begin
      failures++;
      $display("FAIL blank_drain got=%b exp=1", b_fdone);
    end
    repeat (5) tick();
    checks++;
    if ({b_tvalid, b_fcnt} !== {1'b0, 16'd2}) begin
      failures++;
      $display("FAIL blank_idle got=%h exp=%h", {b_tvalid, b_fcnt}, {1'b0, 16'd2});
    end
  endtask

  task automatic test_channels;
    logic [24:0] exp_v, got_v;
    int n = 0;
    c_mode = 2'd0; c_tready = 1'b1; c_en = 1'b1;
    tick();
    for (int b = 0; b < 12; b++) begin
      exp_v = {1'b1, 8'(b + 2), 8'(b + 1), 8'(b)};
      got_v = {c_tvalid, c_tdata};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL chan_beat%0d got=%h exp=%h", b, got_v, exp_v);
      end
      if (b == 5) begin
        checks++;
        if (c_tdata !== 24'h070605) begin
          failures++;
          $display("FAIL chan_beat5_const got=%h exp=070605", c_tdata);
        end
      end
      tick();
    end
    checks++;
    if ({c_tvalid, c_tuser, c_fdone, c_tdata} !== {3'b111, 24'h020100}) begin
      failures++;
      $display("FAIL chan_frame2 got=%h exp=%h", {c_tvalid, c_tuser, c_fdone, c_tdata},
               {3'b111, 24'h020100});
    end
    c_en = 1'b0;
    tick();
    while (!c_fdone && n < 60) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if ({c_tvalid, c_fcnt} !== {1'b0, 16'd2}) begin
      failures++;
      $display("FAIL chan_idle got=%h exp=%h", {c_tvalid, c_fcnt}, {1'b0, 16'd2});
    end
  endtask

  task automatic test_reset_midframe;
    int n = 0;
    a_mode = 2'd0; a_tready = 1'b1; a_en = 1'b1;
    tick();
    repeat (6) tick();
    checks++;
    if ({a_tvalid, a_tdata} !== {1'b1, 8'd6}) begin
      failures++;
      $display("FAIL rstmid_beat6 got=%h exp=%h", {a_tvalid, a_tdata}, {1'b1, 8'd6});
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({a_tvalid, a_tlast, a_tuser, a_fdone, a_tdata, a_fcnt, c_fcnt} !== 44'h0) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=0",
               {a_tvalid, a_tlast, a_tuser, a_fdone, a_tdata, a_fcnt, c_fcnt});
    end
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if (a_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_sync1 got=%b exp=0", a_tvalid);
    end
    tick();
    checks++;
    if (a_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_sync2 got=%b exp=0", a_tvalid);
    end
    while (!a_tvalid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if ({a_tvalid, a_tuser, a_tdata} !== {2'b11, 8'd0}) begin
      failures++;
      $display("FAIL rstmid_restart got=%h exp=%h", {a_tvalid, a_tuser, a_tdata}, {2'b11, 8'd0});
    end
    a_en = 1'b0;
    n = 0;
    while (!a_fdone && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ({a_fdone, a_fcnt} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL rstmid_done got=%h exp=%h", {a_fdone, a_fcnt}, {1'b1, 16'd1});
    end
    tick();
  endtask

  task automatic test_mode3;
    logic [7:0] exp0, exp1;
    int n = 0;
`ifdef AXIS_VGEN_LFSR_EN
    exp0 = 8'hE1; exp1 = 8'hC3;
`else
    exp0 = 8'h00; exp1 = 8'h00;
`endif
    a_mode = 2'd3; a_tready = 1'b1; a_en = 1'b1;
    tick();
    a_en = 1'b0;
    checks++;
    if ({a_tvalid, a_tdata} !== {1'b1, exp0}) begin
      failures++;
      $display("FAIL mode3_beat0 got=%h exp=%h", {a_tvalid, a_tdata}, {1'b1, exp0});
    end
    tick();
    checks++;
    if ({a_tvalid, a_tdata} !== {1'b1, exp1}) begin
      failures++;
      $display("FAIL mode3_beat1 got=%h exp=%h", {a_tvalid, a_tdata}, {1'b1, exp1});
    end
    while (!a_fdone && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ({a_fdone, a_fcnt} !== {1'b1, 16'd2}) begin
      failures++;
      $display("FAIL mode3_done got=%h exp=%h", {a_fdone, a_fcnt}, {1'b1, 16'd2});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_en_drop();
    test_blanking();
    test_channels();
    test_reset_midframe();
    test_mode3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
